// File: rtl/seg7_display_ctrl.sv
// seg7_display_ctrl: latches signed values written to the display port,
// converts them to sign + 3 BCD digits (sequential double-dabble) and
// time-multiplexes the result onto a 4-digit seven-segment display.
//
// Ports:
//   clk      system clock, rising edge
//   rst      asynchronous active-high reset
//   p1_we    display write strobe
//   p1_data  signed N-bit value written to the display
//   seg      segment drive, active-low, seg[0]=a .. seg[6]=g
//   an       digit enables, active-low one-hot, an[0] = rightmost digit
//   busy     high while a conversion is running or a value is pending
module seg7_display_ctrl #(
  parameter int unsigned N           = 8,
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         p1_we,
  input  logic [N-1:0] p1_data,
  output logic [6:0]   seg,
  output logic [3:0]   an,
  output logic         busy
);

  localparam int unsigned BCD_W = 12;
  localparam int unsigned BIT_W = $clog2(N);
  localparam int unsigned CNT_W = $clog2(REFRESH_DIV);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONVERT,
    S_LOAD
  } state_t;

  state_t             state;
  logic               pending;
  logic [N-1:0]       pend_data;
  logic [BIT_W-1:0]   bit_cnt;
  logic [N-1:0]       mag;
  logic [BCD_W-1:0]   bcd;
  logic               work_sign;
  logic               disp_sign;
  logic [BCD_W-1:0]   disp_bcd;
  logic [CNT_W-1:0]   ref_cnt;
  logic [1:0]         sel;

  logic [N-1:0]       cap_val;
  logic [BCD_W-1:0]   bcd_shift;
  logic [1:0]         sel_nxt;
  logic [6:0]         seg_nxt;

  // Two's-complement magnitude; the most negative value maps to 2^(N-1).
  function automatic logic [N-1:0] abs_val(input logic [N-1:0] v);
    return v[N-1] ? N'(~v + 1'b1) : v;
  endfunction

  // Double-dabble correction: add 3 to each nibble that is 5 or more.
  function automatic logic [BCD_W-1:0] dd_adjust(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int i = 0; i < 3; i++) begin
      if (r[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

  function automatic logic [6:0] enc(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return SEG_BLANK;
    endcase
  endfunction

  // A fresh strobe in IDLE beats a stored pending value.
  assign cap_val   = p1_we ? p1_data : pend_data;
  assign bcd_shift = BCD_W'({dd_adjust(bcd), mag[N-1]});

  // Conversion FSM with display registers and pending slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      pending   <= 1'b0;
      pend_data <= '0;
      bit_cnt   <= '0;
      mag       <= '0;
      bcd       <= '0;
      work_sign <= 1'b0;
      disp_sign <= 1'b0;
      disp_bcd  <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          busy <= p1_we || pending;
          if (p1_we || pending) begin
            work_sign <= cap_val[N-1];
            mag       <= abs_val(cap_val);
            bcd       <= '0;
            bit_cnt   <= '0;
            pending   <= 1'b0;
            state     <= S_CONVERT;
          end
        end
        S_CONVERT: begin
          bcd     <= bcd_shift;
          mag     <= {mag[N-2:0], 1'b0};
          bit_cnt <= bit_cnt + BIT_W'(1);
          if (bit_cnt == BIT_W'(N - 1)) state <= S_LOAD;
        end
        S_LOAD: begin
          disp_sign <= work_sign;
          disp_bcd  <= bcd;
          state     <= S_IDLE;
          busy      <= pending || p1_we;
        end
        default: state <= S_IDLE;
      endcase
      // Strobes during a conversion park in the one-deep pending slot.
      if (p1_we && (state != S_IDLE)) begin
        pend_data <= p1_data;
        pending   <= 1'b1;
        busy      <= 1'b1;
      end
    end
  end

  assign sel_nxt = sel + 2'd1;

  // Segment pattern for the digit about to be selected.
  always_comb begin
    seg_nxt = SEG_BLANK;
    case (sel_nxt)
      2'd3: seg_nxt = disp_sign ? SEG_MINUS : SEG_BLANK;
      2'd2: seg_nxt = (disp_bcd[11:8] == 4'd0) ? SEG_BLANK : enc(disp_bcd[11:8]);
      2'd1: seg_nxt = (disp_bcd[11:4] == 8'd0) ? SEG_BLANK : enc(disp_bcd[7:4]);
      default: seg_nxt = enc(disp_bcd[3:0]);
    endcase
  end

  // Refresh scan; seg/an load on the same edge the select advances.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_cnt <= '0;
      sel     <= 2'd0;
      an      <= 4'b1110;
      seg     <= 7'b1000000;
    end else if (ref_cnt == CNT_W'(REFRESH_DIV - 1)) begin
      ref_cnt <= '0;
      sel     <= sel_nxt;
      an      <= ~(4'b0001 << sel_nxt);
      seg     <= seg_nxt;
    end else begin
      ref_cnt <= ref_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_seg7_display_ctrl.sv
// Directed bench for seg7_display_ctrl with N=8 and a 4-cycle refresh slot.
module tb_seg7_display_ctrl;

  localparam int unsigned N  = 8;
  localparam int unsigned RD = 4;

  localparam logic [6:0] BL = 7'b1111111;
  localparam logic [6:0] MI = 7'b0111111;
  localparam logic [6:0] D0 = 7'b1000000;
  localparam logic [6:0] D1 = 7'b1111001;
  localparam logic [6:0] D2 = 7'b0100100;
  localparam logic [6:0] D3 = 7'b0110000;
  localparam logic [6:0] D4 = 7'b0011001;
  localparam logic [6:0] D8 = 7'b0000000;
  localparam logic [6:0] D9 = 7'b0010000;

  logic         clk;
  logic         rst;
  logic         p1_we;
  logic [N-1:0] p1_data;
  logic [6:0]   seg;
  logic [3:0]   an;
  logic         busy;

  int checks = 0;
  int errors = 0;

  seg7_display_ctrl #(.N(N), .REFRESH_DIV(RD)) dut (
    .clk     (clk),
    .rst     (rst),
    .p1_we   (p1_we),
    .p1_data (p1_data),
    .seg     (seg),
    .an      (an),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic strobe(input logic [N-1:0] v);
    @(negedge clk);
    p1_we   = 1'b1;
    p1_data = v;
    @(negedge clk);
    p1_we   = 1'b0;
  endtask

  // Collect one full scan rotation and compare each digit slot.
  task automatic read_display(input string tag, input logic [6:0] e3, input logic [6:0] e2,
                              input logic [6:0] e1, input logic [6:0] e0);
    logic [6:0] d [4];
    for (int i = 0; i < 4; i++) d[i] = 7'bx;
    repeat (RD) @(negedge clk);
    repeat (4 * RD) begin
      @(negedge clk);
      case (an)
        4'b1110: d[0] = seg;
        4'b1101: d[1] = seg;
        4'b1011: d[2] = seg;
        4'b0111: d[3] = seg;
        default: ;
      endcase
    end
    check({tag, "_dig3"}, 16'(d[3]), 16'(e3));
    check({tag, "_dig2"}, 16'(d[2]), 16'(e2));
    check({tag, "_dig1"}, 16'(d[1]), 16'(e1));
    check({tag, "_dig0"}, 16'(d[0]), 16'(e0));
  endtask

  // Align to the start of digit 0 and follow the select round the display.
  task automatic check_scan(input logic [6:0] e3, input logic [6:0] e2,
                            input logic [6:0] e1, input logic [6:0] e0);
    logic [3:0] prev;
    logic       found;
    logic [3:0] exp_an [4];
    logic [6:0] exp_seg [4];
    exp_an  = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
    exp_seg = '{e1, e2, e3, e0};
    found = 1'b0;
    prev  = an;
    for (int i = 0; i < 10 * RD && !found; i++) begin
      @(negedge clk);
      if (an == 4'b1110 && prev != 4'b1110) found = 1'b1;
      prev = an;
    end
    check("scan_sync", 16'(found), 16'd1);
    for (int i = 0; i < 4; i++) begin
      repeat (RD) @(negedge clk);
      check($sformatf("scan_an%0d", i), 16'(an), 16'(exp_an[i]));
      check($sformatf("scan_seg%0d", i), 16'(seg), 16'(exp_seg[i]));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst     = 1'b1;
    p1_we   = 1'b0;
    p1_data = '0;
    repeat (3) @(negedge clk);
    check("rst_an", 16'(an), 16'(4'b1110));
    check("rst_seg", 16'(seg), 16'(D0));
    check("rst_busy", 16'(busy), 16'd0);
    rst = 1'b0;
    read_display("rst", BL, BL, BL, D0);

    // 123: busy through the conversion and the load cycle only
    strobe(8'h7B);
    check("pos_busy_start", 16'(busy), 16'd1);
    repeat (N) @(negedge clk);
    check("pos_busy_load", 16'(busy), 16'd1);
    @(negedge clk);
    check("pos_busy_done", 16'(busy), 16'd0);
    read_display("pos123", BL, D1, D2, D3);

    strobe(8'h80);
    repeat (N + 1) @(negedge clk);
    check("m128_busy", 16'(busy), 16'd0);
    read_display("m128", MI, D1, D2, D8);

    strobe(8'hFF);
    repeat (N + 1) @(negedge clk);
    check("m1_busy", 16'(busy), 16'd0);
    read_display("m1", MI, BL, BL, D1);

    // 5, 7, 9 back to back: 5 converts, 9 overwrites 7 in pending
    @(negedge clk);
    p1_we   = 1'b1;
    p1_data = 8'd5;
    @(negedge clk);
    p1_data = 8'd7;
    @(negedge clk);
    p1_data = 8'd9;
    @(negedge clk);
    p1_we   = 1'b0;
    repeat (7) @(negedge clk);
    check("pend_busy_gap", 16'(busy), 16'd1);
    repeat (9) @(negedge clk);
    check("pend_busy_second", 16'(busy), 16'd1);
    @(negedge clk);
    check("pend_busy_done", 16'(busy), 16'd0);
    read_display("pend9", BL, BL, BL, D9);

    // reset in the middle of a conversion
    strobe(8'h64);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_busy", 16'(busy), 16'd0);
    check("midrst_an", 16'(an), 16'(4'b1110));
    check("midrst_seg", 16'(seg), 16'(D0));
    @(negedge clk);
    rst = 1'b0;
    read_display("midrst", BL, BL, BL, D0);
    strobe(8'h0A);
    repeat (N + 1) @(negedge clk);
    check("ten_busy", 16'(busy), 16'd0);
    read_display("ten", BL, BL, D1, D0);

    // 42 and the scan order
    strobe(8'h2A);
    repeat (N + 1) @(negedge clk);
    read_display("v42", BL, BL, D4, D2);
    check_scan(BL, BL, D4, D2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
